// File: rtl/matmul_pkg.sv
// Shared types and constants for the matmul operand loader and its consumers.
// Dimensions are 1..M; element storage is wide enough for a full M-term dot product.
package matmul_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int M          = 32;
  localparam int DIM_W      = $clog2(M) + 1;
  localparam int IDX_W      = $clog2(M);
  localparam int ELEM_W     = 2 * DATA_WIDTH + $clog2(M);

  typedef logic signed [ELEM_W-1:0] mat_elem;
  typedef logic [DIM_W-1:0]         dim_t;
  typedef logic [IDX_W-1:0]         idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    ISSUE  = 2'd3
  } loader_state_e;

  function automatic logic dim_legal(input dim_t d);
    return (d != '0) && (d <= dim_t'(M));
  endfunction
endpackage

// File: rtl/rc_counter.sv
// Row/column position counter for a row-major stream; wraps column at i_col_lim,
// returns to (0,0) after the final position and flags that position with o_last.
module rc_counter
  import matmul_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_inc,
  input  dim_t i_col_lim,
  input  dim_t i_row_lim,
  output idx_t o_row,
  output idx_t o_col,
  output logic o_last
);
  idx_t r_row;
  idx_t r_col;
  logic w_col_end;
  logic w_row_end;

  assign w_col_end = (dim_t'(r_col) == (i_col_lim - dim_t'(1)));
  assign w_row_end = (dim_t'(r_row) == (i_row_lim - dim_t'(1)));
  assign o_last    = w_col_end && w_row_end;
  assign o_row     = r_row;
  assign o_col     = r_col;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_inc) begin
      if (o_last) begin
        r_row <= '0;
        r_col <= '0;
      end else if (w_col_end) begin
        r_col <= '0;
        r_row <= r_row + idx_t'(1);
      end else begin
        r_col <= r_col + idx_t'(1);
      end
    end
  end
endmodule

// File: rtl/matmul_loader.sv
// Loads two zero-padded MxM operand arrays from a row-major element stream and
// launches matmul with a single start pulse once it is idle.
module matmul_loader
  import matmul_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  dim_t                         cfg_rows,
  input  dim_t                         cfg_cols,
  input  dim_t                         cfg_cols2,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         mm_busy,
  output mat_elem                      mat1 [M][M],
  output mat_elem                      mat2 [M][M],
  output logic                         start,
  output logic                         err,
  output logic                         busy,
  output loader_state_e                dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on valid, and valid is ignored while ready is low.

  loader_state_e r_state;
  loader_state_e w_next_state;
  dim_t          r_rows;
  dim_t          r_cols;
  dim_t          r_cols2;
  logic          r_start;
  logic          r_err;
  logic          w_start_next;
  logic          w_cfg_fire;
  logic          w_cfg_legal;
  logic          w_load;
  logic          w_in_fire;
  dim_t          w_col_lim;
  dim_t          w_row_lim;
  idx_t          w_row;
  idx_t          w_col;
  logic          w_last;
  mat_elem       w_elem;
  mat_elem       r_mat1 [M][M];
  mat_elem       r_mat2 [M][M];

  assign cfg_ready   = (r_state == IDLE) && !mm_busy && !r_start;
  assign w_cfg_fire  = cfg_valid && cfg_ready;
  assign w_cfg_legal = dim_legal(cfg_rows) && dim_legal(cfg_cols) && dim_legal(cfg_cols2);
  assign w_load      = w_cfg_fire && w_cfg_legal;
  assign in_ready    = (r_state == LOAD_A) || (r_state == LOAD_B);
  assign w_in_fire   = in_valid && in_ready;
  assign w_elem      = {{(ELEM_W-DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};

  assign start     = r_start;
  assign err       = r_err;
  assign busy      = (r_state != IDLE);
  assign dbg_state = r_state;
  assign mat1      = r_mat1;
  assign mat2      = r_mat2;

  // mat2 is cols x cols2, so the B phase reuses cols as its row limit.
  assign w_col_lim = (r_state == LOAD_B) ? r_cols2 : r_cols;
  assign w_row_lim = (r_state == LOAD_B) ? r_cols  : r_rows;

  rc_counter u_rc (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_load),
    .i_inc     (w_in_fire),
    .i_col_lim (w_col_lim),
    .i_row_lim (w_row_lim),
    .o_row     (w_row),
    .o_col     (w_col),
    .o_last    (w_last)
  );

  always_comb begin
    w_next_state = r_state;
    w_start_next = 1'b0;
    case (r_state)
      IDLE:    if (w_load) w_next_state = LOAD_A;
      LOAD_A:  if (w_in_fire && w_last) w_next_state = LOAD_B;
      LOAD_B:  if (w_in_fire && w_last) w_next_state = ISSUE;
      ISSUE: begin
        if (!mm_busy) begin
          w_start_next = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_start <= 1'b0;
      r_err   <= 1'b0;
      r_rows  <= '0;
      r_cols  <= '0;
      r_cols2 <= '0;
    end else begin
      r_state <= w_next_state;
      r_start <= w_start_next;
      r_err   <= w_cfg_fire && !w_cfg_legal;
      if (w_load) begin
        r_rows  <= cfg_rows;
        r_cols  <= cfg_cols;
        r_cols2 <= cfg_cols2;
      end
    end
  end

  // Clearing on descriptor accept is what makes the padding region read zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < M; i++) begin
        for (int j = 0; j < M; j++) begin
          r_mat1[i][j] <= '0;
          r_mat2[i][j] <= '0;
        end
      end
    end else if (w_load) begin
      for (int i = 0; i < M; i++) begin
        for (int j = 0; j < M; j++) begin
          r_mat1[i][j] <= '0;
          r_mat2[i][j] <= '0;
        end
      end
    end else if (w_in_fire) begin
      if (r_state == LOAD_A) r_mat1[w_row][w_col] <= w_elem;
      else                   r_mat2[w_row][w_col] <= w_elem;
    end
  end
endmodule

// File: doc/matmul_loader.md
# matmul_loader

Upstream feeder for `matmul`. Accepts a dimension descriptor and a row-major element stream over valid/ready handshakes. Assembles the two zero-padded M×M operand arrays that drive `matmul`'s `mat1`/`mat2`, then pulses `start` once the multiplier is idle. Because padding is zero, the full M×M product is correct in its top-left rows×cols2 region for any legal shape.

## Interface
- `DATA_WIDTH`, 16: signed width of each streamed element.
- `M`, 32: maximum matrix dimension; array size is M×M.
- `DIM_W`, $clog2(M)+1: width of the dimension fields.
- `clk` in, 1: clock; all state updates on the rising edge.
- `reset` in, 1: asynchronous, active-low reset.
- `cfg_valid` in, 1: descriptor valid.
- `cfg_ready` out, 1: descriptor accepted when both valid and ready are high.
- `cfg_rows` in, DIM_W: rows of mat1.
- `cfg_cols` in, DIM_W: cols of mat1, which is also rows of mat2.
- `cfg_cols2` in, DIM_W: cols of mat2.
- `in_valid` in, 1: element valid.
- `in_ready` out, 1: element accepted when both valid and ready are high.
- `in_data` in, DATA_WIDTH: signed element.
- `mm_busy` in, 1: matmul is computing; operand arrays must stay stable while high.
- `mat1` out, M×M mat_elem: operand A.
- `mat2` out, M×M mat_elem: operand B.
- `start` out, 1: one-cycle pulse that launches matmul.
- `err` out, 1: one-cycle pulse on an illegal descriptor.
- `busy` out, 1: high whenever state ≠ IDLE.

## Operation
- States and transitions:
  - IDLE → LOAD_A on an accepted legal descriptor.
  - LOAD_A → LOAD_B after rows×cols beats.
  - LOAD_B → ISSUE after cols×cols2 beats.
  - ISSUE → IDLE when start is issued.
- Descriptor acceptance:
  - `cfg_ready = (state==IDLE) && !mm_busy && !start`.
  - Legal means every dimension is in 1..M.
- On accepting a legal descriptor:
  - Latch rows/cols/cols2.
  - Clear all of mat1 and mat2 to 0 in that same cycle.
  - Zero row/col counters.
- On an illegal descriptor (any dimension 0 or >M):
  - Pulse `err` on the next cycle.
  - Consume the descriptor, stay in IDLE.
  - mat1/mat2 are untouched.
- Element acceptance: `in_ready = (state==LOAD_A) || (state==LOAD_B)`.
- Each accepted beat writes at (r,c):
  - LOAD_A writes mat1[r][c]; LOAD_B writes mat2[r][c].
  - Then c increments. At the phase's column limit c wraps to 0 and r increments.
  - Limits are cols in LOAD_A and cols2 in LOAD_B.
  - On the phase's final beat, r and c return to 0 and the state advances.
- Width rule: mat_elem is signed [2·DATA_WIDTH+$clog2(M)−1:0], 37 bits at defaults; in_data is sign-extended into it.
- In ISSUE, on the first cycle with `mm_busy==0`:
  - Register `start<=1`.
  - Go to IDLE.
- mat1/mat2 hold their values until the next legal descriptor is accepted.
- `in_valid` is ignored outside the load states. `cfg_valid` is ignored outside IDLE.

## Timing
- Reset values:
  - state IDLE, all counters 0.
  - mat1/mat2 all zero.
  - start 0, err 0, busy 0.
  - cfg_ready follows `!mm_busy`; in_ready 0.
- Reset mid-operation aborts the load immediately with the values above. No start is issued for the partial load.
- Throughput: one element per cycle. Bubbles on in_valid stall the counters only.
- Latency from the last LOAD_B beat (edge t):
  - state is ISSUE after t.
  - start is high in cycle t+2 when mm_busy is low.
  - Otherwise start is high in the cycle after mm_busy is first sampled low.
- `start` is never high for two consecutive cycles.
- cfg_ready stays low during the start cycle, giving matmul one cycle to raise mm_busy.
- A descriptor presented during the cycle reset deasserts is accepted only at the first edge with reset high.
- Minimum total cycles for a 32×32·32×32 job is 1 (cfg) + 2048 (beats) + 2 (issue), i.e. 2051.

## Structure
- Shared package `matmul_pkg` holds:
  - DATA_WIDTH, M, DIM_W.
  - `mat_elem` typedef and `dim_t` typedef.
  - State enum `loader_state_e`.
- matmul and the bench import `matmul_pkg`.
- Sub-module `rc_counter`: a 2-D row/col counter with programmable column/row limits, a `clr` input and a `last` flag. Instantiated once, reloaded per phase.

## Test plan
- Cfg (2,2,2), stream 1,2,3,4,5,6,7,8 with no gaps, mm_busy=0:
  - mat1 = [[1,2],[3,4]], mat2 = [[5,6],[7,8]], every other entry 0.
  - Single start pulse 2 cycles after beat 8.
  - matmul output [[19,22],[43,50]].
- in_data = 16'hFFFF and 16'h8000:
  - Elements read as −1 (all ones) and −32768 with full 37-bit sign extension.
- Illegal descriptors (0,4,4) and (33,2,2):
  - err pulses one cycle each, in_ready stays 0, busy stays 0, no start.
- Hold mm_busy=1 for 10 cycles after the last beat:
  - start stays low.
  - start rises the cycle after mm_busy is sampled low.
  - cfg_ready is 0 throughout and during the start cycle.
- Load 32×32·32×32 of all 3s, then (13,17,19) with random values and random in_valid gaps:
  - Entries outside 13×17 and 17×19 read 0.
  - matmul output matches the software reference.
- Assert reset low midway through LOAD_B:
  - All outputs return to reset values asynchronously.
  - A following (2,2,2) job completes correctly.
